rtc_init_sequencer: RTL and testbench

Parametrised playback engine for the RTC initialisation table. It holds a constant table of register bytes and steps through it after a start pulse, presenting one entry at a time on a valid/ready handshake. Playback ends at a terminator byte or at the table depth. It sits between the top-level control FSM and the RTC bus write controller, and replaces the bare address-to-data lookup used so far.

---
 rtl/rtc_init_sequencer.sv | 127 ++++++++++++
 tb/tb_rtc_init_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_init_sequencer.sv
// rtc_init_sequencer: plays back the constant RTC initialisation table one
// entry at a time on a valid/ready handshake. Playback stops at the
// terminator byte (never presented) or when the index reaches DEPTH.
module rtc_init_sequencer #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 4,
  parameter int                DEPTH      = 10,
  parameter logic [DATA_W-1:0] TERMINATOR = DATA_W'(8'hFF),
  parameter int                GAP_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              data_ready_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic [ADDR_W-1:0] index_out_o,
  output logic              data_valid_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRESENT, S_GAP, S_DONE} state_t;

  state_t            state_q;
  // One extra bit so idx == DEPTH is representable when DEPTH == 2**ADDR_W.
  logic [ADDR_W:0]   idx_q;
  logic [7:0]        gap_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] index_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rom_d;

  // Constant table; anything past the populated entries reads as FF.
  function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W:0] a);
    case (int'(a))
      0, 1, 2, 3, 6, 7, 8: rom = '0;
      4, 5:                rom = DATA_W'(8'h01);
      default:             rom = DATA_W'(8'hFF);
    endcase
  endfunction

  // Table lookup for the current index; captured into data_q in FETCH.
  always_comb rom_d = rom(idx_q);

  // Playback FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (state_q != S_IDLE && abort_i) begin
      // Abort beats a handshake completing in the same cycle.
      state_q <= S_IDLE;
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          data_q  <= '0;
          index_q <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          if (start_i && !abort_i) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (idx_q == (ADDR_W+1)'(DEPTH) || rom_d == TERMINATOR) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            data_q  <= rom_d;
            index_q <= idx_q[ADDR_W-1:0];
            valid_q <= 1'b1;
            state_q <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // Entry is held until accepted; idx only advances on acceptance.
          if (data_ready_i) begin
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= idx_q + 1'b1;
            if (GAP_CYCLES == 0) begin
              state_q <= S_FETCH;
            end else begin
              gap_q   <= 8'(GAP_CYCLES - 1);
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q == 8'd0) state_q <= S_FETCH;
          else               gap_q   <= gap_q - 8'd1;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out_o   = data_q;
  assign index_out_o  = index_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Bench for rtc_init_sequencer: three instances (default, GAP_CYCLES=3,
// DEPTH=4). Accepted entries are checked against a scoreboard queue filled
// from the expected table when each playback is launched.
module tb_rtc_init_sequencer;

  typedef struct {
    logic [7:0] d;
    logic [3:0] i;
  } ent_t;

  typedef struct {
    bit st;
    bit rdy;
    bit v;
    bit b;
    bit d;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       st   [3];
  logic       ab   [3];
  logic       rdy  [3];
  logic [7:0] dout [3];
  logic [3:0] iout [3];
  logic       vld  [3];
  logic       bsy  [3];
  logic       dn   [3];

  int   checks;
  int   failures;
  int   cyc;
  int   ndone;
  int   done_cyc;
  ent_t sb[$];
  logic [7:0] exp_tbl [9];
  vec_t vt [22];

  rtc_init_sequencer u0 (
    .clk_i(clk), .reset_i(rst), .start_i(st[0]), .abort_i(ab[0]),
    .data_ready_i(rdy[0]), .data_out_o(dout[0]), .index_out_o(iout[0]),
    .data_valid_o(vld[0]), .busy_o(bsy[0]), .done_o(dn[0]));

  rtc_init_sequencer #(.GAP_CYCLES(3)) u1 (
    .clk_i(clk), .reset_i(rst), .start_i(st[1]), .abort_i(ab[1]),
    .data_ready_i(rdy[1]), .data_out_o(dout[1]), .index_out_o(iout[1]),
    .data_valid_o(vld[1]), .busy_o(bsy[1]), .done_o(dn[1]));

  rtc_init_sequencer #(.DEPTH(4)) u2 (
    .clk_i(clk), .reset_i(rst), .start_i(st[2]), .abort_i(ab[2]),
    .data_ready_i(rdy[2]), .data_out_o(dout[2]), .index_out_o(iout[2]),
    .data_valid_o(vld[2]), .busy_o(bsy[2]), .done_o(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Queue the first n expected table entries for a playback.
  task automatic push(input int n);
    ent_t e;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      e.d = exp_tbl[i];
      e.i = 4'(i);
      sb.push_back(e);
    end
    ndone    = 0;
    done_cyc = -1;
  endtask

  // Sample instance k in the current cycle: score an accepted entry, note done.
  task automatic smp(input int k);
    ent_t e;
    if (vld[k] && rdy[k] && !ab[k] && !rst) begin
      if (sb.size() == 0) begin
        chk("sb_extra_entry", int'(iout[k]), -1);
      end else begin
        e = sb.pop_front();
        chk("sb_data", int'(dout[k]), int'(e.d));
        chk("sb_index", int'(iout[k]), int'(e.i));
      end
    end
    if (dn[k]) begin
      ndone++;
      done_cyc = cyc;
    end
  endtask

  // Default playback on u0 driven from the vector table.
  task automatic run_default();
    push(9);
    for (int c = 0; c < 22; c++) begin
      cyc    = c;
      st[0]  = vt[c].st;
      rdy[0] = vt[c].rdy;
      chk("dflt_valid", int'(vld[0]), int'(vt[c].v));
      chk("dflt_busy", int'(bsy[0]), int'(vt[c].b));
      chk("dflt_done", int'(dn[0]), int'(vt[c].d));
      smp(0);
      tick();
    end
    st[0] = 1'b0;
    chk("dflt_sb_empty", sb.size(), 0);
    chk("dflt_ndone", ndone, 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    exp_tbl  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int c = 0; c < 22; c++) begin
      vt[c].st  = (c == 0);
      vt[c].rdy = 1'b1;
      vt[c].v   = (c >= 2 && c <= 18 && c % 2 == 0);
      vt[c].b   = (c >= 1 && c <= 19);
      vt[c].d   = (c == 20);
    end
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; ab[k] = 1'b0; rdy[k] = 1'b1;
    end

    // Reset state of all instances
    rst = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_data", int'(dout[k]), 0);
      chk("rst_index", int'(iout[k]), 0);
      chk("rst_valid", int'(vld[k]), 0);
      chk("rst_busy", int'(bsy[k]), 0);
      chk("rst_done", int'(dn[k]), 0);
    end
    rst = 1'b0;
    tick();

    // Default run
    run_default();
    tick();

    // Backpressure on index 4
    push(9);
    for (int c = 0; c < 28; c++) begin
      cyc    = c;
      st[0]  = (c == 0);
      rdy[0] = !(c >= 10 && c <= 14);
      if (c >= 10 && c <= 14) begin
        chk("bp_valid", int'(vld[0]), 1);
        chk("bp_data", int'(dout[0]), 1);
        chk("bp_index", int'(iout[0]), 4);
      end
      if (c == 17) begin
        chk("bp_next_valid", int'(vld[0]), 1);
        chk("bp_next_index", int'(iout[0]), 5);
      end
      smp(0);
      tick();
    end
    rdy[0] = 1'b1;
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_ndone", ndone, 1);
    chk("bp_done_cyc", done_cyc, 25);

    // GAP_CYCLES=3
    push(9);
    for (int c = 0; c < 50; c++) begin
      cyc   = c;
      st[1] = (c == 0);
      chk("gap_valid", int'(vld[1]), int'(c >= 2 && c <= 42 && (c - 2) % 5 == 0));
      smp(1);
      tick();
    end
    chk("gap_sb_empty", sb.size(), 0);
    chk("gap_ndone", ndone, 1);
    chk("gap_done_cyc", done_cyc, 47);

    // DEPTH=4: stops after index 3 with no terminator
    push(4);
    for (int c = 0; c < 13; c++) begin
      cyc   = c;
      st[2] = (c == 0);
      chk("depth_valid", int'(vld[2]), int'(c >= 2 && c <= 8 && c % 2 == 0));
      smp(2);
      tick();
    end
    chk("depth_sb_empty", sb.size(), 0);
    chk("depth_ndone", ndone, 1);
    chk("depth_done_cyc", done_cyc, 10);

    // Start pulsed while index 2 is presented
    push(9);
    for (int c = 0; c < 23; c++) begin
      cyc   = c;
      st[0] = (c == 0 || c == 6);
      if (c == 6) chk("sb2_index2", int'(iout[0]), 2);
      if (c == 8) begin
        chk("sb2_valid", int'(vld[0]), 1);
        chk("sb2_index3", int'(iout[0]), 3);
      end
      smp(0);
      tick();
    end
    st[0] = 1'b0;
    chk("sb2_sb_empty", sb.size(), 0);
    chk("sb2_ndone", ndone, 1);
    chk("sb2_done_cyc", done_cyc, 20);

    // Abort while index 5 is presented with ready high
    push(5);
    for (int c = 0; c < 18; c++) begin
      cyc   = c;
      st[0] = (c == 0);
      ab[0] = (c == 12);
      if (c == 12) chk("abort_pre_index", int'(iout[0]), 5);
      if (c == 13) begin
        chk("abort_valid", int'(vld[0]), 0);
        chk("abort_busy", int'(bsy[0]), 0);
        chk("abort_data", int'(dout[0]), 0);
        chk("abort_index", int'(iout[0]), 0);
      end
      smp(0);
      tick();
    end
    ab[0] = 1'b0;
    chk("abort_sb_empty", sb.size(), 0);
    chk("abort_ndone", ndone, 0);

    // Reset in the same spot
    push(5);
    for (int c = 0; c < 16; c++) begin
      cyc   = c;
      st[0] = (c == 0);
      rst   = (c == 12);
      if (c == 13) begin
        chk("mrst_valid", int'(vld[0]), 0);
        chk("mrst_busy", int'(bsy[0]), 0);
        chk("mrst_done", int'(dn[0]), 0);
        chk("mrst_data", int'(dout[0]), 0);
        chk("mrst_index", int'(iout[0]), 0);
      end
      smp(0);
      tick();
    end
    rst = 1'b0;
    chk("mrst_sb_empty", sb.size(), 0);
    chk("mrst_ndone", ndone, 0);

    // Fresh start replays from index 0
    run_default();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
